param_ram_clr: RTL

PARAM_RAM_CLR -- requirements
Module: param_ram_clr

---
 rtl/param_ram_clr_if.sv | 29 ++
 rtl/param_ram_clr.sv | 87 ++++++++
 2 files changed

// File: rtl/param_ram_clr_if.sv
// param_ram_clr_if: write, read and clear-control bus of param_ram_clr.
interface param_ram_clr_if #(
    parameter int DATA_WIDTH = 32,
    parameter int BYTE_W     = 8,
    parameter int ADDR_WIDTH = 10
);
    localparam int NB = DATA_WIDTH / BYTE_W;
    logic                  wr_en;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [NB-1:0]         wr_be;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  rd_en;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  rd_valid;
    logic                  clear_req;
    logic                  clear_busy;
    logic                  clear_done;
    logic                  addr_err;
    logic                  wr_drop;
    modport master (
        output wr_en, wr_addr, wr_be, wr_data, rd_en, rd_addr, clear_req,
        input  rd_data, rd_valid, clear_busy, clear_done, addr_err, wr_drop
    );
    modport slave (
        input  wr_en, wr_addr, wr_be, wr_data, rd_en, rd_addr, clear_req,
        output rd_data, rd_valid, clear_busy, clear_done, addr_err, wr_drop
    );
endinterface

// File: rtl/param_ram_clr.sv
// param_ram_clr: byte-enabled 1R1W RAM with registered read and a whole-array zero sweep.
module param_ram_clr #(
    parameter int DATA_WIDTH     = 32,
    parameter int BYTE_W         = 8,
    parameter int ADDR_WIDTH     = 10,
    parameter int DEPTH          = 1024,
    parameter int RDW_MODE       = 0,
    parameter int CLEAR_ON_RESET = 1
) (
    input logic            clk,
    input logic            rst_n,
    param_ram_clr_if.slave bus
);
    localparam int NB = DATA_WIDTH / BYTE_W;
    localparam logic [ADDR_WIDTH:0]   LIM  = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(DEPTH - 1);

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t                r_state, w_next;
    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [ADDR_WIDTH-1:0] r_ptr;
    logic [DATA_WIDTH-1:0] r_rd_data;
    logic                  r_rd_valid, r_clear_done, r_addr_err, r_wr_drop;
    logic [DATA_WIDTH-1:0] w_old, w_merged, w_rd_word;
    logic                  w_wr_oob, w_rd_oob, w_wr_ok, w_last, w_clr;

    assign w_clr    = r_state == CLEAR;
    assign w_wr_oob = {1'b0, bus.wr_addr} >= LIM;
    assign w_rd_oob = {1'b0, bus.rd_addr} >= LIM;
    assign w_wr_ok  = rst_n && !w_clr && bus.wr_en && !w_wr_oob;
    assign w_last   = w_clr && r_ptr == LAST;
    assign w_old    = r_mem[bus.rd_addr];

    always_comb begin
        w_merged = w_old;
        for (int i = 0; i < NB; i++)
            if (bus.wr_be[i]) w_merged[i*BYTE_W +: BYTE_W] = bus.wr_data[i*BYTE_W +: BYTE_W];
    end

    // Mode 1 forwards whatever this edge will store: merged write data, or zero under the sweep.
    always_comb
        w_rd_word = w_rd_oob ? '0 :
                    (RDW_MODE != 0 && w_clr && bus.rd_addr == r_ptr) ? '0 :
                    (RDW_MODE != 0 && w_wr_ok && bus.wr_addr == bus.rd_addr) ? w_merged : w_old;

    always_comb
        w_next = !w_clr ? (bus.clear_req ? CLEAR : IDLE) : (w_last ? IDLE : CLEAR);

    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= (CLEAR_ON_RESET != 0) ? CLEAR : IDLE;
        else        r_state <= w_next;
    end

    always_ff @(posedge clk) begin
        if (rst_n && w_clr)
            r_mem[r_ptr] <= '0;
        else if (w_wr_ok)
            for (int i = 0; i < NB; i++)
                if (bus.wr_be[i]) r_mem[bus.wr_addr][i*BYTE_W +: BYTE_W] <= bus.wr_data[i*BYTE_W +: BYTE_W];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ptr        <= '0;
            r_rd_data    <= '0;
            r_rd_valid   <= 1'b0;
            r_clear_done <= 1'b0;
            r_addr_err   <= 1'b0;
            r_wr_drop    <= 1'b0;
        end else begin
            r_ptr        <= w_clr ? (w_last ? '0 : r_ptr + 1'b1) : r_ptr;
            r_rd_data    <= bus.rd_en ? w_rd_word : r_rd_data;
            r_rd_valid   <= bus.rd_en;
            r_clear_done <= w_last;
            r_addr_err   <= (bus.rd_en && w_rd_oob) || (bus.wr_en && !w_clr && w_wr_oob);
            r_wr_drop    <= bus.wr_en && w_clr;
        end
    end

    assign bus.rd_data    = r_rd_data;
    assign bus.rd_valid   = r_rd_valid;
    assign bus.clear_busy = w_clr;
    assign bus.clear_done = r_clear_done;
    assign bus.addr_err   = r_addr_err;
    assign bus.wr_drop    = r_wr_drop;
endmodule
